// File: rtl/mem_nb_stage.sv
// Non-blocking memory-response stage between EXE and WB: an in-order queue of in-flight
// instructions, matching in-order data_ok responses and retiring extended load data in order.
module mem_nb_stage #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_req,
  input  logic                         in_is_load,
  input  logic [3:0]                   in_mem_op,
  input  logic [31:0]                  in_alu_result,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic                         data_ok,
  input  logic [31:0]                  rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_wdata,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   cancel_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned SUM_W = CNT_W + 2;

  localparam logic [3:0] OP_LD_B  = 4'd0;
  localparam logic [3:0] OP_LD_H  = 4'd1;
  localparam logic [3:0] OP_LD_W  = 4'd2;
  localparam logic [3:0] OP_LD_BU = 4'd8;
  localparam logic [3:0] OP_LD_HU = 4'd9;

  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic                 r_is_load [DEPTH];
  logic [3:0]           r_mem_op  [DEPTH];
  logic [31:0]          r_alu     [DEPTH];
  logic [31:0]          r_rdata   [DEPTH];
  logic [DEPTH-1:0]     r_done;

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     r_cancel;

  logic                 w_tgt_hit;
  logic [PTR_W-1:0]     w_tgt_idx;
  logic [PTR_W-1:0]     w_scan_idx;
  logic [CNT_W-1:0]     w_undone;
  logic                 w_out_valid;
  logic                 w_deq_ok;
  logic                 w_deq;
  logic                 w_in_ready;
  logic                 w_fire;
  logic                 w_cancel_take;
  logic                 w_resp_q;
  logic                 w_resp_in;
  logic [SUM_W-1:0]     w_fl_sum;
  logic [SUM_W-1:0]     w_fl_adj;
  logic                 w_fl_sub;

  // Oldest undone valid entry is the response target; also count undone entries.
  always_comb begin
    w_tgt_hit  = 1'b0;
    w_tgt_idx  = r_head;
    w_scan_idx = r_head;
    w_undone   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count && !r_done[w_scan_idx]) begin
        w_undone = w_undone + CNT_W'(1);
        if (!w_tgt_hit) begin
          w_tgt_hit = 1'b1;
          w_tgt_idx = w_scan_idx;
        end
      end
    end
  end

  assign w_out_valid   = (r_count != '0) & r_done[r_head];
  assign w_deq_ok      = w_out_valid & out_ready;
  assign w_deq         = w_deq_ok & ~flush;
  assign w_in_ready    = ((r_count < CNT_W'(DEPTH)) | w_deq_ok) & (r_cancel == '0) & ~flush;
  assign w_fire        = in_valid & w_in_ready;
  assign w_cancel_take = data_ok & (r_cancel != '0);
  assign w_resp_q      = data_ok & (r_cancel == '0) & w_tgt_hit;
  assign w_resp_in     = data_ok & (r_cancel == '0) & ~w_tgt_hit & w_fire & in_req;

  // Responses still owed to flushed requests; a response never goes below zero.
  always_comb begin
    w_fl_sum = SUM_W'(r_cancel) - SUM_W'(w_cancel_take) + SUM_W'(w_undone)
             + SUM_W'(in_valid & in_req);
    w_fl_sub = data_ok & (r_cancel == '0);
    w_fl_adj = w_fl_sum;
    if (w_fl_sub) begin
      w_fl_adj = (w_fl_sum != '0) ? (w_fl_sum - SUM_W'(1)) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_cancel <= '0;
      r_done   <= '0;
    end else if (flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_cancel <= CNT_W'(w_fl_adj);
    end else begin
      if (w_cancel_take) r_cancel <= r_cancel - CNT_W'(1);
      if (w_resp_q) r_done[w_tgt_idx] <= 1'b1;
      if (w_fire) begin
        r_done[r_tail] <= ~in_req | w_resp_in;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_deq) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_fire) - CNT_W'(w_deq);
    end
  end

  // Entry payload storage needs no reset: validity lives in the count and done bits.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_payload[r_tail] <= in_payload;
      r_is_load[r_tail] <= in_is_load;
      r_mem_op[r_tail]  <= in_mem_op;
      r_alu[r_tail]     <= in_alu_result;
      if (w_resp_in) r_rdata[r_tail] <= rdata;
    end
    if (w_resp_q && !flush) r_rdata[w_tgt_idx] <= rdata;
  end

  logic [31:0] w_hd_rdata;
  logic [31:0] w_hd_alu;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load extraction from the head entry only, so no rdata-to-output path exists.
  always_comb begin
    w_hd_rdata = r_rdata[r_head];
    w_hd_alu   = r_alu[r_head];
    case (w_hd_alu[1:0])
      2'd0:    w_byte = w_hd_rdata[7:0];
      2'd1:    w_byte = w_hd_rdata[15:8];
      2'd2:    w_byte = w_hd_rdata[23:16];
      default: w_byte = w_hd_rdata[31:24];
    endcase
    w_half = w_hd_alu[1] ? w_hd_rdata[31:16] : w_hd_rdata[15:0];
    out_wdata = w_hd_alu;
    if (r_is_load[r_head]) begin
      case (r_mem_op[r_head])
        OP_LD_B:  out_wdata = {{24{w_byte[7]}}, w_byte};
        OP_LD_BU: out_wdata = {24'h0, w_byte};
        OP_LD_H:  out_wdata = {{16{w_half[15]}}, w_half};
        OP_LD_HU: out_wdata = {16'h0, w_half};
        OP_LD_W:  out_wdata = w_hd_rdata;
        default:  out_wdata = 32'h0;
      endcase
    end
  end

  assign out_valid   = w_out_valid;
  assign out_payload = r_payload[r_head];
  assign in_ready    = w_in_ready;
  assign pend_cnt    = r_count;
  assign cancel_cnt  = r_cancel;

endmodule
